// File: rtl/tw_seq_pkg.sv
// Shared types, default widths and the twiddle address mapping for the
// radix-2 DIF twiddle ROM sequencer.
package tw_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tw_state_e;

  localparam int STAGE_FFT_DEF = 8;
  localparam int ADDR_W_DEF    = STAGE_FFT_DEF - 1;
  localparam int STG_W_DEF     = $clog2(STAGE_FFT_DEF);

  // Stage s keeps the low (addr_w - s) bits of k and shifts them up by s,
  // so each stage touches every 2^s-th ROM entry; the last stage is W^0.
  function automatic logic [31:0] tw_addr(input int addr_w, input int s, input int k);
    logic [31:0] mask;
    logic [31:0] full;
    mask = (32'd1 << (addr_w - s)) - 32'd1;
    full = (32'd1 << addr_w) - 32'd1;
    return ((32'(k) & mask) << s) & full;
  endfunction

endpackage

// File: rtl/tw_addr_sequencer.sv
// Issues one twiddle ROM read per unstalled cycle across every stage of an
// FFT frame and produces qualifiers aligned to the ROM's registered output.
module tw_addr_sequencer
  import tw_seq_pkg::*;
#(
  parameter int stage_FFT = STAGE_FFT_DEF,
  parameter int ADDR_W    = stage_FFT - 1,
  parameter int STG_W     = $clog2(stage_FFT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              en_rd,
  output logic [ADDR_W-1:0] rd_ptr_angle,
  output logic              tw_valid,
  output logic [STG_W-1:0]  tw_stage,
  output logic              tw_last,
  output logic              done
);

  localparam logic [ADDR_W-1:0] K_LAST = '1;
  localparam logic [STG_W-1:0]  S_LAST = STG_W'(stage_FFT - 1);

  tw_state_e         state_q, state_d;
  logic [STG_W-1:0]  s_q, s_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tw_valid_q, tw_valid_d;
  logic [STG_W-1:0]  tw_stage_q, tw_stage_d;
  logic              tw_last_q, tw_last_d;
  logic              issue;
  logic              last_issue;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    k_d        = k_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    tw_valid_d = tw_valid_q;
    tw_stage_d = tw_stage_q;
    tw_last_d  = tw_last_q;

    unique case (state_q)
      IDLE: begin
        // The done cycle is spent in IDLE; a start seen there is dropped.
        if (start && !done_q) begin
          state_d = RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (k_q == K_LAST) begin
            k_d = '0;
            if (s_q == S_LAST) begin
              last_issue = 1'b1;
              s_d        = '0;
              state_d    = DRAIN;
            end else begin
              s_d = s_q + STG_W'(1);
            end
          end else begin
            k_d = k_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Qualifiers track the ROM output register, which only loads when unstalled.
    if (!stall) begin
      tw_valid_d = issue;
      tw_stage_d = issue ? s_q : '0;
      tw_last_d  = last_issue;
    end

    busy_d = (state_d != IDLE) || done_d;
  end

  always_comb begin
    addr = '0;
    if (state_q == RUN) begin
      addr = ADDR_W'(tw_addr(ADDR_W, int'(s_q), int'(k_q)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tw_valid_q <= 1'b0;
      tw_stage_q <= '0;
      tw_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tw_valid_q <= tw_valid_d;
      tw_stage_q <= tw_stage_d;
      tw_last_q  <= tw_last_d;
    end
  end

  assign busy         = busy_q;
  assign en_rd        = issue;
  assign rd_ptr_angle = addr;
  assign tw_valid     = tw_valid_q;
  assign tw_stage     = tw_stage_q;
  assign tw_last      = tw_last_q;
  assign done         = done_q;

endmodule

// File: tb/tb_tw_addr_sequencer.sv
// Directed bench: a stage_FFT=3 instance driven from a vector table plus
// corner sequences, and a stage_FFT=8 instance checked over a full frame.
module tb_tw_addr_sequencer;
  import tw_seq_pkg::*;

  logic clk;
  logic rst;
  logic start, stall;
  logic busy, en_rd, tw_valid, tw_last, done;
  logic [1:0] rd_ptr;
  logic [1:0] tw_stage;

  logic start8, stall8;
  logic busy8, en8, tw_valid8, tw_last8, done8;
  logic [6:0] rd_ptr8;
  logic [2:0] tw_stage8;

  int checks = 0;
  int errors = 0;

  tw_addr_sequencer #(.stage_FFT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy),
    .en_rd(en_rd), .rd_ptr_angle(rd_ptr), .tw_valid(tw_valid),
    .tw_stage(tw_stage), .tw_last(tw_last), .done(done)
  );

  tw_addr_sequencer #(.stage_FFT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .stall(stall8), .busy(busy8),
    .en_rd(en8), .rd_ptr_angle(rd_ptr8), .tw_valid(tw_valid8),
    .tw_stage(tw_stage8), .tw_last(tw_last8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic stall;
    logic en;
    int   addr;
    logic valid;
    int   stg;
    logic last;
    logic done;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic st, input logic sl, input logic en, input int addr,
                              input logic val, input int stg, input logic last,
                              input logic dn, input logic bz);
    vec_t v;
    v.start = st; v.stall = sl; v.en = en; v.addr = addr; v.valid = val;
    v.stg = stg; v.last = last; v.done = dn; v.busy = bz;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic en, input int addr, input logic val,
                         input int stg, input logic last, input logic dn, input logic bz);
    chk({tag, ".en_rd"}, int'(en_rd), int'(en));
    chk({tag, ".addr"}, int'(rd_ptr), addr);
    chk({tag, ".tw_valid"}, int'(tw_valid), int'(val));
    chk({tag, ".tw_stage"}, int'(tw_stage), stg);
    chk({tag, ".tw_last"}, int'(tw_last), int'(last));
    chk({tag, ".done"}, int'(done), int'(dn));
    chk({tag, ".busy"}, int'(busy), int'(bz));
  endtask

  initial begin
    int reads, vcnt, busy_cnt, done_cnt, s, k;
    logic prev_en, fin, done_seen;
    int base;

    // Plain frame, start pulsed once
    add(1,0, 0,0, 0,0,0, 0,0);
    add(0,0, 1,0, 0,0,0, 0,1);
    add(0,0, 1,1, 1,0,0, 0,1);
    add(0,0, 1,2, 1,0,0, 0,1);
    add(0,0, 1,3, 1,0,0, 0,1);
    add(0,0, 1,0, 1,0,0, 0,1);
    add(0,0, 1,2, 1,1,0, 0,1);
    add(0,0, 1,0, 1,1,0, 0,1);
    add(0,0, 1,2, 1,1,0, 0,1);
    add(0,0, 1,0, 1,1,0, 0,1);
    add(0,0, 1,0, 1,2,0, 0,1);
    add(0,0, 1,0, 1,2,0, 0,1);
    add(0,0, 1,0, 1,2,0, 0,1);
    add(0,0, 0,0, 1,2,1, 0,1);
    add(0,0, 0,0, 0,0,0, 1,1);
    add(0,0, 0,0, 0,0,0, 0,0);
    // Frame with a 3-cycle stall at the first stage-1 issue
    add(1,0, 0,0, 0,0,0, 0,0);
    add(0,0, 1,0, 0,0,0, 0,1);
    add(0,0, 1,1, 1,0,0, 0,1);
    add(0,0, 1,2, 1,0,0, 0,1);
    add(0,0, 1,3, 1,0,0, 0,1);
    add(0,1, 0,0, 1,0,0, 0,1);
    add(0,1, 0,0, 1,0,0, 0,1);
    add(0,1, 0,0, 1,0,0, 0,1);
    add(0,0, 1,0, 1,0,0, 0,1);
    add(0,0, 1,2, 1,1,0, 0,1);
    add(0,0, 1,0, 1,1,0, 0,1);
    add(0,0, 1,2, 1,1,0, 0,1);
    add(0,0, 1,0, 1,1,0, 0,1);
    add(0,0, 1,0, 1,2,0, 0,1);
    add(0,0, 1,0, 1,2,0, 0,1);
    add(0,0, 1,0, 1,2,0, 0,1);
    add(0,0, 0,0, 1,2,1, 0,1);
    add(0,0, 0,0, 0,0,0, 1,1);
    add(0,0, 0,0, 0,0,0, 0,0);
    // Start held high across a whole frame and its done cycle
    base = vecs.size();
    for (int j = 0; j < 14; j++) begin
      vec_t v;
      v = vecs[j];
      v.start = 1'b1;
      vecs.push_back(v);
    end
    add(1,0, 0,0, 0,0,0, 1,1);
    add(1,0, 0,0, 0,0,0, 0,0);
    add(0,0, 1,0, 0,0,0, 0,1);

    rst = 1'b1; start = 1'b0; stall = 1'b0; start8 = 1'b0; stall8 = 1'b0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    chk("reset.busy8", int'(busy8), 0);
    chk("reset.en8", int'(en8), 0);
    chk("reset.valid8", int'(tw_valid8), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start;
      stall = vecs[i].stall;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].valid,
              vecs[i].stg, vecs[i].last, vecs[i].done, vecs[i].busy);
      tick();
    end
    start = 1'b0;
    stall = 1'b0;

    // Reset at the 7th issue of the frame started by the held start
    for (int n = 2; n <= 6; n++) begin
      #1;
      chk($sformatf("abort.issue%0d.en", n), int'(en_rd), 1);
      chk($sformatf("abort.issue%0d.addr", n), int'(rd_ptr), int'(tw_addr(2, (n - 1) / 4, (n - 1) % 4)));
      tick();
    end
    rst = 1'b1;
    #1;
    chk("abort.issue7.en", int'(en_rd), 1);
    chk("abort.issue7.addr", int'(rd_ptr), 0);
    tick();
    rst = 1'b0;
    #1;
    chk_all("abort.after", 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("abort.no_done", int'(done), 0);
      chk("abort.idle_en", int'(en_rd), 0);
    end

    // Clean frame after the abort
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    reads = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (en_rd) begin
        chk($sformatf("post_abort.addr%0d", reads), int'(rd_ptr), int'(tw_addr(2, reads / 4, reads % 4)));
        reads++;
      end
      if (done) done_seen = 1'b1;
      tick();
    end
    chk("post_abort.reads", reads, 12);
    chk("post_abort.done_seen", int'(done_seen), 1);

    // Stall held for two cycles in DRAIN
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      #1;
      chk($sformatf("drain.issue%0d.en", n), int'(en_rd), 1);
      tick();
    end
    stall = 1'b1;
    #1;
    chk_all("drain.stall0", 0, 0, 1, 2, 1, 0, 1);
    tick();
    chk_all("drain.stall1", 0, 0, 1, 2, 1, 0, 1);
    tick();
    stall = 1'b0;
    #1;
    chk_all("drain.release", 0, 0, 1, 2, 1, 0, 1);
    tick();
    chk_all("drain.done", 0, 0, 0, 0, 0, 1, 1);
    tick();
    chk_all("drain.idle", 0, 0, 0, 0, 0, 0, 0);

    // Full stage_FFT=8 frame
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    reads = 0; vcnt = 0; busy_cnt = 0; done_cnt = 0;
    prev_en = 1'b0;
    fin = 1'b0;
    for (int c = 0; c < 2000 && !fin; c++) begin
      chk("n8.valid_follows_en", int'(tw_valid8), int'(prev_en));
      if (busy8) busy_cnt++;
      if (en8) begin
        s = reads / 128;
        k = reads % 128;
        chk($sformatf("n8.addr%0d", reads), int'(rd_ptr8), int'(tw_addr(7, s, k)));
        if (s == 0) chk("n8.stage0_addr", int'(rd_ptr8), k);
        if (s == 7) chk("n8.stage7_addr", int'(rd_ptr8), 0);
        reads++;
      end
      if (tw_valid8) begin
        chk("n8.tw_stage", int'(tw_stage8), vcnt / 128);
        chk("n8.tw_last", int'(tw_last8), (vcnt == 1023) ? 1 : 0);
        vcnt++;
      end
      if (done8) done_cnt++;
      if (done_cnt > 0 && !busy8) fin = 1'b1;
      prev_en = en8;
      tick();
    end
    chk("n8.finished", int'(fin), 1);
    chk("n8.reads", reads, 1024);
    chk("n8.valids", vcnt, 1024);
    chk("n8.busy_cycles", busy_cnt, 1026);
    chk("n8.done_pulses", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
